// File: rtl/arrow_lane_engine_pkg.sv
// ddr_pkg: grade encoding, timing windows and lane index width shared by the arrow engine
package ddr_pkg;

    typedef enum logic [1:0] {
        GOOD      = 2'd0,
        GREAT     = 2'd1,
        PERFECT   = 2'd2,
        MARVELOUS = 2'd3
    } grade_e;

    localparam int MARV_W  = 7;
    localparam int PERF_W  = 17;
    localparam int GREAT_W = 37;
    localparam int GOOD_W  = 52;

    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arrow_lane_engine_if.sv
// arrow_lane_engine_if: launch, button, playfield and judgement signals of the arrow engine
interface arrow_lane_engine_if
    import ddr_pkg::*;
#(
    parameter int CORDW   = 10,
    parameter int N_LANES = 4,
    parameter int SLOTS   = 4,
    parameter int COMBO_W = 10
);
    localparam int LW = lane_idx_w(N_LANES);
    logic                           frame_i;
    logic                           launch_valid_i;
    logic [LW-1:0]                  launch_lane_i;
    logic                           launch_ready_o;
    logic [N_LANES-1:0]             btn_i;
    logic [N_LANES*SLOTS*CORDW-1:0] arrow_y_o;
    logic [N_LANES*SLOTS-1:0]       arrow_active_o;
    logic [N_LANES-1:0]             judge_valid_o;
    logic [N_LANES*2-1:0]           judge_grade_o;
    logic [N_LANES-1:0]             miss_o;
    logic [COMBO_W-1:0]             combo_o;

    modport slave (
        input  frame_i, launch_valid_i, launch_lane_i, btn_i,
        output launch_ready_o, arrow_y_o, arrow_active_o, judge_valid_o, judge_grade_o, miss_o, combo_o
    );

    modport master (
        output frame_i, launch_valid_i, launch_lane_i, btn_i,
        input  launch_ready_o, arrow_y_o, arrow_active_o, judge_valid_o, judge_grade_o, miss_o, combo_o
    );
endinterface

// File: rtl/arrow_lane.sv
// arrow_lane: one lane of arrow slots with allocator, mover, miss detector and nearest-slot grader
module arrow_lane
    import ddr_pkg::*;
#(
    parameter int CORDW        = 10,
    parameter int SLOTS        = 4,
    parameter int ARROWY_BEGIN = 480,
    parameter int SPEED        = 5,
    parameter int TARGET_Y     = 53
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   i_frame,
    input  logic                   i_launch,
    input  logic                   i_btn,
    output logic [SLOTS*CORDW-1:0] o_y,
    output logic [SLOTS-1:0]       o_active,
    output logic                   o_free,
    output logic                   o_hit,
    output logic                   o_miss_evt,
    output logic                   o_judge_valid,
    output grade_e                 o_judge_grade,
    output logic                   o_miss
);
    localparam logic [CORDW-1:0] L_BEGIN = CORDW'(ARROWY_BEGIN);
    localparam logic [CORDW-1:0] L_SPEED = CORDW'(SPEED);
    localparam logic [CORDW:0]   L_TGT   = (CORDW+1)'(TARGET_Y);
    logic [CORDW-1:0] r_y [SLOTS];
    logic [SLOTS-1:0] r_active, w_sel, w_hit_slot, w_miss_slot, w_alloc;
    logic [CORDW:0]   w_best, w_d;
    logic             w_found, w_press, r_btn_prev, r_judge_valid, r_miss;
    grade_e           w_grade, r_grade;

    // nearest active slot to the receptor; strict < keeps the lowest index on ties
    always_comb begin
        w_sel   = '0;
        w_best  = '1;
        w_found = 1'b0;
        w_d     = '0;
        for (int s = 0; s < SLOTS; s++) begin
            w_d = ({1'b0, r_y[s]} >= L_TGT) ? {1'b0, r_y[s]} - L_TGT : L_TGT - {1'b0, r_y[s]};
            if (r_active[s] && (!w_found || w_d < w_best)) begin
                w_found = 1'b1;
                w_best  = w_d;
                w_sel   = SLOTS'(1) << s;
            end
        end
    end

    // grade from the candidate distance
    always_comb begin
        w_grade = (w_best <= (CORDW+1)'(MARV_W))  ? MARVELOUS :
                  (w_best <= (CORDW+1)'(PERF_W))  ? PERFECT   :
                  (w_best <= (CORDW+1)'(GREAT_W)) ? GREAT     : GOOD;
    end

    assign w_press       = i_btn & ~r_btn_prev;
    assign o_hit         = w_press && w_found && (w_best <= (CORDW+1)'(GOOD_W));
    assign w_hit_slot    = o_hit ? w_sel : '0;
    assign w_alloc       = i_launch ? (~r_active & (r_active + SLOTS'(1))) : '0;
    assign o_free        = ~&r_active;
    assign o_miss_evt    = |w_miss_slot;
    assign o_active      = r_active;
    assign o_judge_valid = r_judge_valid;
    assign o_judge_grade = r_grade;
    assign o_miss        = r_miss;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign o_y[s*CORDW +: CORDW] = r_y[s];
        assign w_miss_slot[s] = i_frame && r_active[s] && !w_hit_slot[s] && (r_y[s] < L_SPEED);
    end

    // slot state: hit or miss frees, frame moves, launch fills the lowest slot free at cycle start
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_active <= '0;
            for (int s = 0; s < SLOTS; s++) r_y[s] <= L_BEGIN;
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_hit_slot[s] || w_miss_slot[s]) begin
                    r_active[s] <= 1'b0;
                    r_y[s]      <= L_BEGIN;
                end else if (r_active[s] && i_frame) begin
                    r_y[s] <= r_y[s] - L_SPEED;
                end else if (w_alloc[s]) begin
                    r_active[s] <= 1'b1;
                    r_y[s]      <= L_BEGIN;
                end
            end
        end
    end

    // button history and registered judgement pulses; history resets high so a held button is not a press
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_btn_prev    <= 1'b1;
            r_judge_valid <= 1'b0;
            r_grade       <= GOOD;
            r_miss        <= 1'b0;
        end else begin
            r_btn_prev    <= i_btn;
            r_judge_valid <= o_hit;
            r_grade       <= o_hit ? w_grade : GOOD;
            r_miss        <= o_miss_evt;
        end
    end
endmodule

// File: rtl/arrow_lane_engine.sv
// arrow_lane_engine: multi-lane arrow playfield with launch demux, ready mux and saturating combo
module arrow_lane_engine
    import ddr_pkg::*;
#(
    parameter int CORDW        = 10,
    parameter int N_LANES      = 4,
    parameter int SLOTS        = 4,
    parameter int ARROWY_BEGIN = 480,
    parameter int SPEED        = 5,
    parameter int TARGET_Y     = 53,
    parameter int COMBO_W      = 10
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    arrow_lane_engine_if.slave  bus
);
    localparam int LW = lane_idx_w(N_LANES);
    localparam int SW = COMBO_W + LW + 1;
    logic [N_LANES-1:0] w_free, w_hit, w_miss_evt;
    logic               w_ready;
    logic [SW-1:0]      w_sum;
    logic [COMBO_W-1:0] r_combo;

    // ready only for an existing lane that still has a free slot
    always_comb begin
        w_ready = 1'b0;
        for (int l = 0; l < N_LANES; l++) if (int'(bus.launch_lane_i) == l) w_ready = w_free[l];
    end

    assign bus.launch_ready_o = w_ready;
    assign bus.combo_o        = r_combo;

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        arrow_lane #(
            .CORDW(CORDW), .SLOTS(SLOTS), .ARROWY_BEGIN(ARROWY_BEGIN), .SPEED(SPEED), .TARGET_Y(TARGET_Y)
        ) u_lane (
            .clk_i        (clk_i),
            .reset_ni     (reset_ni),
            .i_frame      (bus.frame_i),
            .i_launch     (bus.launch_valid_i && w_ready && (bus.launch_lane_i == LW'(l))),
            .i_btn        (bus.btn_i[l]),
            .o_y          (bus.arrow_y_o[l*SLOTS*CORDW +: SLOTS*CORDW]),
            .o_active     (bus.arrow_active_o[l*SLOTS +: SLOTS]),
            .o_free       (w_free[l]),
            .o_hit        (w_hit[l]),
            .o_miss_evt   (w_miss_evt[l]),
            .o_judge_valid(bus.judge_valid_o[l]),
            .o_judge_grade(bus.judge_grade_o[2*l +: 2]),
            .o_miss       (bus.miss_o[l])
        );
    end

    // any miss restarts the combo, then this cycle's hits are added
    always_comb begin
        w_sum = (|w_miss_evt) ? '0 : SW'(r_combo);
        for (int l = 0; l < N_LANES; l++) w_sum = w_sum + SW'(w_hit[l]);
    end

    // combo register saturating at all ones
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) r_combo <= '0;
        else r_combo <= (w_sum > SW'({COMBO_W{1'b1}})) ? '1 : w_sum[COMBO_W-1:0];
    end
endmodule
